// File: rtl/cfg_chain_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cfg_chain_loader_if
//  Brief    : Bitstream word stream (valid/ready) into the config chain loader.
//  Revision : 1.0  initial release
// ============================================================================
interface cfg_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_in, output word_valid, input  word_ready);
    modport slave  (input  word_in, input  word_valid, output word_ready);
endinterface

`default_nettype wire

// File: rtl/cfg_chain_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cfg_chain_loader
//  Brief    : Serialises bitstream words MSB-first into the fabric config chain,
//             counts CHAIN_LEN shifts, then releases config mode.
//             Optional CRC-16/CCITT-FALSE check enabled by macro CFG_CRC_EN.
//  Revision : 1.0  initial release
// ============================================================================
module cfg_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 256,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               start,
    input  logic               abort,
    cfg_chain_loader_if.slave  stream,
    input  logic [15:0]        exp_crc,
    output logic               cfg_data_out,
    output logic               cfg_shift_en,
    output logic               cfg_en,
    input  logic               cfg_data_in,
    output logic               busy,
    output logic               done,
    output logic               error
);
    localparam int                 c_WB_W      = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]   c_LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [c_WB_W-1:0]  c_WORD_BITS = c_WB_W'(WORD_W);
    localparam logic [c_WB_W-1:0]  c_ONE_BIT   = c_WB_W'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_SHIFT = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [WORD_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [c_WB_W-1:0] r_word_left;
    logic              r_error;
    logic              w_accept_start;
    logic              w_accept_word;
    logic              w_crc_bad;

    assign w_accept_start = (r_state == c_IDLE) && start && !abort;
    assign w_accept_word  = (r_state == c_LOAD) && stream.word_valid && !abort;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // abort wins over every other transition once a load is in progress
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept_start) w_state_next = c_LOAD;
            end
            c_LOAD: begin
                if (abort)                  w_state_next = c_IDLE;
                else if (stream.word_valid) w_state_next = c_SHIFT;
            end
            c_SHIFT: begin
                if (abort)                           w_state_next = c_IDLE;
                else if (r_bit_cnt == c_LAST_BIT)    w_state_next = c_DONE;
                else if (r_word_left == c_ONE_BIT)   w_state_next = c_LOAD;
            end
            c_DONE: begin
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    always_comb begin
        stream.word_ready = 1'b0;
        cfg_shift_en      = 1'b0;
        cfg_data_out      = 1'b0;
        busy              = (r_state != c_IDLE);
        cfg_en            = (r_state != c_IDLE);
        done              = 1'b0;
        error             = r_error;
        case (r_state)
            c_LOAD:  stream.word_ready = 1'b1;
            c_SHIFT: begin
                cfg_shift_en = 1'b1;
                cfg_data_out = r_shift[WORD_W-1];
            end
            c_DONE: begin
                done  = !w_crc_bad;
                error = r_error | w_crc_bad;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_word_left <= '0;
            r_error     <= 1'b0;
        end else begin
            if (w_accept_start) begin
                r_bit_cnt <= '0;
                r_error   <= 1'b0;
            end
            if ((r_state != c_IDLE) && abort) begin
                r_error <= 1'b1;
            end else if ((r_state == c_DONE) && w_crc_bad) begin
                r_error <= 1'b1;
            end
            if (w_accept_word) begin
                r_shift     <= stream.word_in;
                r_word_left <= c_WORD_BITS;
            end else if (r_state == c_SHIFT) begin
                r_shift     <= r_shift << 1;
                r_bit_cnt   <= r_bit_cnt + CNT_W'(1);
                r_word_left <= r_word_left - c_ONE_BIT;
            end
        end
    end

`ifdef CFG_CRC_EN
    logic [15:0] r_crc;
    logic [15:0] r_exp_crc;
    logic [15:0] w_crc_next;
    logic        w_unused;

    // CRC covers exactly the bits presented while cfg_shift_en is high
    always_comb begin
        w_crc_next = {r_crc[14:0], 1'b0};
        if (r_crc[15] ^ r_shift[WORD_W-1]) w_crc_next = w_crc_next ^ 16'h1021;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_crc     <= 16'hFFFF;
            r_exp_crc <= 16'h0000;
        end else if (w_accept_start) begin
            r_crc     <= 16'hFFFF;
            r_exp_crc <= exp_crc;
        end else if (r_state == c_SHIFT) begin
            r_crc     <= w_crc_next;
        end
    end

    assign w_crc_bad = (r_crc != r_exp_crc);
    assign w_unused  = cfg_data_in;
`else
    logic w_unused;

    assign w_crc_bad = 1'b0;
    assign w_unused  = ^{cfg_data_in, exp_crc};
`endif

endmodule

`default_nettype wire
